ps2_dir_arbiter: RTL and testbench
==================================

PS2_DIR_ARBITER -- requirements
Module: ps2_dir_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 2500000, idle cycles (50 ms at 50 MHz) after which a partial prefix sequence is abandoned.
REQ-002 CLOCK_50  input  1  system clock, all logic on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 rx_data  input  8  received PS/2 byte from PS2_Controller.
REQ-005 rx_valid  input  1  one-cycle strobe, rx_data valid.
REQ-006 dir_out  output  4  one-hot active direction {up,down,left,right}, registered.
REQ-007 held  output  4  currently held keys {up,down,left,right}, registered.
REQ-008 turn_valid  output  1  pending turn request.
REQ-009 turn_dir  output  2  requested direction: 0 up, 1 down, 2 left, 3 right.
REQ-010 turn_ready  input  1  game logic accepts the request when turn_valid is high.

Function
REQ-011 Make codes SHALL be 1D up, 1B down, 1C left, 23 right; extended codes (after E0) SHALL be 75 up, 72 down, 6B left, 74 right.
REQ-012 Prefix FSM states SHALL be IDLE, EXT, BRK and EXT_BRK, advancing only on rx_valid.
REQ-013 IDLE: E0 -> EXT; F0 -> BRK; a direction code -> press event, stays IDLE; any other byte -> stays IDLE.
REQ-014 EXT: F0 -> EXT_BRK; an extended direction code -> press event, then IDLE; any other byte -> IDLE.
REQ-015 BRK: a direction code -> release event; any byte -> IDLE.
REQ-016 EXT_BRK: an extended direction code -> release event; any byte -> IDLE.
REQ-017 A press sets the held bit, and a release clears it; held updates one cycle after the rx_valid cycle.
REQ-018 A press of a key not already held is a new press and SHALL load last_dir with that direction.
REQ-019 A press of an already-held key (typematic repeat) SHALL change neither last_dir nor the turn request.
REQ-020 dir_out SHALL be one-hot last_dir while that key is held; otherwise the highest-priority held key (up>down>left>right); otherwise 0000.
REQ-021 dir_out SHALL update in the same cycle as held.
REQ-022 A new press SHALL set turn_valid=1 and turn_dir=pressed direction one cycle after rx_valid.
REQ-023 turn_valid SHALL clear on the cycle after turn_valid&turn_ready, unless a new press arrives that same cycle.
REQ-024 A new press while a request is pending SHALL overwrite turn_dir, latest wins, with turn_valid remaining 1.
REQ-025 turn_dir SHALL be stable while turn_valid=1 and no new press arrives.
REQ-026 Idle counter SHALL clear on rx_valid, and it saturates.
REQ-027 When the FSM is not IDLE and the counter reaches TIMEOUT_CYCLES-1, the FSM SHALL return to IDLE; held is not affected.

Reset
REQ-028 On reset: FSM IDLE, counter 0, held=0000, dir_out=0000, last_dir=0, turn_valid=0, turn_dir=0.
REQ-029 Reset SHALL override any simultaneous rx_valid or handshake, and mid-sequence prefixes are discarded.

Configuration
REQ-030 With PS2_ARROW_KEYS_EN defined, extended arrow codes are decoded per REQ-011/014/016.
REQ-031 Without PS2_ARROW_KEYS_EN, EXT and EXT_BRK still consume their bytes, but no extended code produces a press or release.

Structure
REQ-032 Package pacman_input_pkg SHALL hold the direction encoding, scan-code constants (make, extended, E0, F0) and the FSM state type.
REQ-033 Prefix decoding SHALL be a sub-module ps2_prefix_fsm that emits press/release events with a direction; held, arbitration and handshake logic stay in ps2_dir_arbiter.

Verification
REQ-034 Send 1D -> held=1000, dir_out=1000, turn_valid=1, turn_dir=0; with turn_ready=1 for one cycle, turn_valid=0.
REQ-035 Send 1D, then 23, then F0 23 -> dir_out 1000, 0001, then 1000; held ends 1000.
REQ-036 Send 1C three times (repeat) with turn_ready=0, then pulse turn_ready -> one request only with turn_dir=2, then turn_valid=0.
REQ-037 Send 1B then 1C with turn_ready=0 -> turn_dir=2, turn_valid=1; a new press in the same cycle as the handshake keeps turn_valid=1.
REQ-038 With the macro defined, send E0 75 and then E0 F0 75 -> dir_out 1000 then 0000; without the macro, dir_out stays 0000.
REQ-039 Send F0, wait TIMEOUT_CYCLES idle cycles, send 1D -> press of up (not a release); assert reset mid-sequence -> all outputs 0.

Source files
------------

// File: rtl/pacman_input_pkg.sv
// pacman_input_pkg: shared definitions for the PS/2 direction input path.
//   - direction encoding (0 up, 1 down, 2 left, 3 right)
//   - PS/2 scan-code constants (make, extended make, E0 and F0 prefixes)
//   - prefix FSM state type and state constants
//   - scan-code decode helpers and direction-to-one-hot helper
package pacman_input_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;

  localparam logic [7:0] SC_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] SC_PREFIX_BRK = 8'hF0;

  localparam logic [7:0] SC_MAKE_UP    = 8'h1D;
  localparam logic [7:0] SC_MAKE_DOWN  = 8'h1B;
  localparam logic [7:0] SC_MAKE_LEFT  = 8'h1C;
  localparam logic [7:0] SC_MAKE_RIGHT = 8'h23;

  localparam logic [7:0] SC_EXT_UP     = 8'h75;
  localparam logic [7:0] SC_EXT_DOWN   = 8'h72;
  localparam logic [7:0] SC_EXT_LEFT   = 8'h6B;
  localparam logic [7:0] SC_EXT_RIGHT  = 8'h74;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE    = 2'd0;
  localparam fsm_state_t ST_EXT     = 2'd1;
  localparam fsm_state_t ST_BRK     = 2'd2;
  localparam fsm_state_t ST_EXT_BRK = 2'd3;

  typedef struct packed {
    logic hit;
    dir_t dir;
  } key_hit_t;

  // Plain (non-extended) direction make codes.
  function automatic key_hit_t decode_make(input logic [7:0] code);
    key_hit_t r;
    r.hit = 1'b1;
    case (code)
      SC_MAKE_UP:    r.dir = DIR_UP;
      SC_MAKE_DOWN:  r.dir = DIR_DOWN;
      SC_MAKE_LEFT:  r.dir = DIR_LEFT;
      SC_MAKE_RIGHT: r.dir = DIR_RIGHT;
      default: begin
        r.hit = 1'b0;
        r.dir = DIR_UP;
      end
    endcase
    return r;
  endfunction

  // Extended (E0-prefixed) arrow-key codes.
  function automatic key_hit_t decode_ext(input logic [7:0] code);
    key_hit_t r;
    r.hit = 1'b1;
    case (code)
      SC_EXT_UP:    r.dir = DIR_UP;
      SC_EXT_DOWN:  r.dir = DIR_DOWN;
      SC_EXT_LEFT:  r.dir = DIR_LEFT;
      SC_EXT_RIGHT: r.dir = DIR_RIGHT;
      default: begin
        r.hit = 1'b0;
        r.dir = DIR_UP;
      end
    endcase
    return r;
  endfunction

  // Direction to {up,down,left,right} one-hot: up is the MSB.
  function automatic logic [3:0] dir_onehot(input dir_t d);
    return 4'b1000 >> d;
  endfunction

endpackage

// File: rtl/ps2_prefix_fsm.sv
// ps2_prefix_fsm: turns the PS/2 byte stream into press/release events for the
// four direction keys, tracking the E0 / F0 prefixes. A partial prefix sequence
// is abandoned after TIMEOUT_CYCLES idle cycles.
// Optional feature: define PS2_ARROW_KEYS_EN to decode the extended arrow keys;
// without it the extended bytes are still consumed but produce no events.
// Ports:
//   CLOCK_50    in   system clock (rising edge)
//   reset       in   synchronous active-high reset
//   rx_data     in   received PS/2 byte
//   rx_valid    in   one-cycle strobe, rx_data valid
//   press_evt   out  direction key pressed (combinational, in the rx_valid cycle)
//   release_evt out  direction key released (combinational, in the rx_valid cycle)
//   evt_dir     out  direction of the event
module ps2_prefix_fsm
  import pacman_input_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       press_evt,
  output logic       release_evt,
  output dir_t       evt_dir
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  fsm_state_t       state_r;
  fsm_state_t       state_eff_s;
  fsm_state_t       state_next_s;
  logic [CNT_W-1:0] idle_cnt_r;
  key_hit_t         make_s;
  key_hit_t         ext_s;

  assign make_s = decode_make(rx_data);
`ifdef PS2_ARROW_KEYS_EN
  assign ext_s = decode_ext(rx_data);
`else
  assign ext_s = {1'b0, DIR_UP};
`endif

  // Timeout folds a stale prefix back to IDLE; a byte arriving in the same
  // cycle is then decoded as if no prefix had been seen.
  always_comb begin
    if ((state_r != ST_IDLE) && (idle_cnt_r == CNT_LAST)) begin
      state_eff_s = ST_IDLE;
    end else begin
      state_eff_s = state_r;
    end
  end

  // Prefix decoding and event generation.
  always_comb begin
    state_next_s = state_eff_s;
    press_evt    = 1'b0;
    release_evt  = 1'b0;
    evt_dir      = DIR_UP;
    if (rx_valid) begin
      case (state_eff_s)
        ST_IDLE: begin
          if (rx_data == SC_PREFIX_EXT) begin
            state_next_s = ST_EXT;
          end else if (rx_data == SC_PREFIX_BRK) begin
            state_next_s = ST_BRK;
          end else if (make_s.hit) begin
            press_evt = 1'b1;
            evt_dir   = make_s.dir;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_EXT: begin
          state_next_s = ST_IDLE;
          if (rx_data == SC_PREFIX_BRK) begin
            state_next_s = ST_EXT_BRK;
          end else if (ext_s.hit) begin
            press_evt = 1'b1;
            evt_dir   = ext_s.dir;
          end else begin
            press_evt = 1'b0;
          end
        end
        ST_BRK: begin
          state_next_s = ST_IDLE;
          if (make_s.hit) begin
            release_evt = 1'b1;
            evt_dir     = make_s.dir;
          end else begin
            release_evt = 1'b0;
          end
        end
        ST_EXT_BRK: begin
          state_next_s = ST_IDLE;
          if (ext_s.hit) begin
            release_evt = 1'b1;
            evt_dir     = ext_s.dir;
          end else begin
            release_evt = 1'b0;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end else begin
      state_next_s = state_eff_s;
    end
  end

  // State register and saturating idle counter (cleared by every byte).
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      idle_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (rx_valid) begin
        idle_cnt_r <= {CNT_W{1'b0}};
      end else if (idle_cnt_r != CNT_LAST) begin
        idle_cnt_r <= idle_cnt_r + CNT_W'(1);
      end else begin
        idle_cnt_r <= idle_cnt_r;
      end
    end
  end

endmodule

// File: rtl/ps2_dir_arbiter.sv
// ps2_dir_arbiter: keyboard direction arbiter for the game. Tracks which
// direction keys are held, selects the active direction (most recent new press
// while still held, else fixed priority up>down>left>right) and raises a
// valid/ready turn request for every new press (latest press wins).
// Optional feature: define PS2_ARROW_KEYS_EN to also accept the extended arrow
// keys (E0-prefixed); see ps2_prefix_fsm.
// Ports:
//   CLOCK_50   in   system clock (rising edge)
//   reset      in   synchronous active-high reset
//   rx_data    in   received PS/2 byte
//   rx_valid   in   one-cycle strobe, rx_data valid
//   dir_out    out  one-hot active direction {up,down,left,right}, registered
//   held       out  held keys {up,down,left,right}, registered
//   turn_valid out  pending turn request
//   turn_dir   out  requested direction (0 up, 1 down, 2 left, 3 right)
//   turn_ready in   game logic accepts the request
module ps2_dir_arbiter
  import pacman_input_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [3:0] dir_out,
  output logic [3:0] held,
  output logic       turn_valid,
  output logic [1:0] turn_dir,
  input  logic       turn_ready
);

  logic       press_s;
  logic       release_s;
  dir_t       evt_dir_s;
  logic [3:0] evt_mask_s;
  logic       new_press_s;
  logic [3:0] held_next_s;
  dir_t       last_dir_next_s;
  logic [3:0] dir_next_s;
  logic       turn_valid_next_s;
  dir_t       turn_dir_next_s;

  logic [3:0] held_r;
  dir_t       last_dir_r;
  logic [3:0] dir_out_r;
  logic       turn_valid_r;
  dir_t       turn_dir_r;

  ps2_prefix_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_prefix_fsm (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .press_evt   (press_s),
    .release_evt (release_s),
    .evt_dir     (evt_dir_s)
  );

  // Held-key update; a press of an already-held key is a typematic repeat.
  always_comb begin
    evt_mask_s  = dir_onehot(evt_dir_s);
    new_press_s = press_s && ((held_r & evt_mask_s) == 4'b0000);
    if (press_s) begin
      held_next_s = held_r | evt_mask_s;
    end else if (release_s) begin
      held_next_s = held_r & ~evt_mask_s;
    end else begin
      held_next_s = held_r;
    end
    if (new_press_s) begin
      last_dir_next_s = evt_dir_s;
    end else begin
      last_dir_next_s = last_dir_r;
    end
  end

  // Active direction from the next-cycle held set so dir_out moves with held.
  always_comb begin
    if ((held_next_s & dir_onehot(last_dir_next_s)) != 4'b0000) begin
      dir_next_s = dir_onehot(last_dir_next_s);
    end else if (held_next_s[3]) begin
      dir_next_s = 4'b1000;
    end else if (held_next_s[2]) begin
      dir_next_s = 4'b0100;
    end else if (held_next_s[1]) begin
      dir_next_s = 4'b0010;
    end else if (held_next_s[0]) begin
      dir_next_s = 4'b0001;
    end else begin
      dir_next_s = 4'b0000;
    end
  end

  // Turn request: a new press beats a simultaneous handshake.
  always_comb begin
    if (new_press_s) begin
      turn_valid_next_s = 1'b1;
      turn_dir_next_s   = evt_dir_s;
    end else if (turn_valid_r && turn_ready) begin
      turn_valid_next_s = 1'b0;
      turn_dir_next_s   = turn_dir_r;
    end else begin
      turn_valid_next_s = turn_valid_r;
      turn_dir_next_s   = turn_dir_r;
    end
  end

  // Output and state registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      held_r       <= 4'b0000;
      last_dir_r   <= DIR_UP;
      dir_out_r    <= 4'b0000;
      turn_valid_r <= 1'b0;
      turn_dir_r   <= DIR_UP;
    end else begin
      held_r       <= held_next_s;
      last_dir_r   <= last_dir_next_s;
      dir_out_r    <= dir_next_s;
      turn_valid_r <= turn_valid_next_s;
      turn_dir_r   <= turn_dir_next_s;
    end
  end

  assign held       = held_r;
  assign dir_out    = dir_out_r;
  assign turn_valid = turn_valid_r;
  assign turn_dir   = turn_dir_r;

endmodule

// File: tb/tb_ps2_dir_arbiter.sv
// Self-checking bench for ps2_dir_arbiter: directed scenarios plus a randomized
// byte stream checked against a key-level reference model.
module tb_ps2_dir_arbiter;

  localparam int TB_T = 16;

`ifdef PS2_ARROW_KEYS_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       turn_ready = 1'b0;
  logic [3:0] dir_out;
  logic [3:0] held;
  logic       turn_valid;
  logic [1:0] turn_dir;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: key-level state, index 0 up .. 3 right.
  bit m_held[4];
  int m_last;
  bit m_tv;
  int m_td;
  bit m_saw_e0;
  bit m_saw_f0;
  int m_since;

  ps2_dir_arbiter #(.TIMEOUT_CYCLES(TB_T)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .dir_out    (dir_out),
    .held       (held),
    .turn_valid (turn_valid),
    .turn_dir   (turn_dir),
    .turn_ready (turn_ready)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic int code_dir(input logic [7:0] b, input bit ext);
    if (ext) begin
      case (b)
        8'h75: return 0;
        8'h72: return 1;
        8'h6B: return 2;
        8'h74: return 3;
        default: return -1;
      endcase
    end else begin
      case (b)
        8'h1D: return 0;
        8'h1B: return 1;
        8'h1C: return 2;
        8'h23: return 3;
        default: return -1;
      endcase
    end
  endfunction

  function automatic logic [3:0] m_held_vec();
    return {m_held[0], m_held[1], m_held[2], m_held[3]};
  endfunction

  function automatic logic [3:0] m_dir_vec();
    logic [3:0] top;
    top = 4'b1000;
    if (m_held[m_last]) return top >> m_last;
    for (int i = 0; i < 4; i++) begin
      if (m_held[i]) return top >> i;
    end
    return 4'b0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_held[i] = 1'b0;
    m_last = 0; m_tv = 1'b0; m_td = 0;
    m_saw_e0 = 1'b0; m_saw_f0 = 1'b0; m_since = 0;
  endtask

  // One clock of the model, applied with the inputs seen at the coming edge.
  task automatic model_cycle(input logic v, input logic [7:0] b, input logic rdy);
    int d;
    bit press, rel, newp;
    press = 1'b0; rel = 1'b0; newp = 1'b0; d = -1;
    if (v) begin
      if (m_since >= TB_T - 1) begin
        m_saw_e0 = 1'b0; m_saw_f0 = 1'b0;
      end
      if (!m_saw_e0 && !m_saw_f0) begin
        if (b == 8'hE0) m_saw_e0 = 1'b1;
        else if (b == 8'hF0) m_saw_f0 = 1'b1;
        else begin
          d = code_dir(b, 1'b0);
          press = (d >= 0);
        end
      end else if (b == 8'hF0 && m_saw_e0 && !m_saw_f0) begin
        m_saw_f0 = 1'b1;
      end else begin
        d = code_dir(b, m_saw_e0);
        if (m_saw_e0 && !EXT_EN) d = -1;
        if (d >= 0) begin
          if (m_saw_f0) rel = 1'b1;
          else press = 1'b1;
        end
        m_saw_e0 = 1'b0; m_saw_f0 = 1'b0;
      end
      m_since = 0;
    end else if (m_since < 1000000) begin
      m_since++;
    end
    if (press && !m_held[d]) begin
      newp = 1'b1; m_held[d] = 1'b1; m_last = d;
    end
    if (rel) m_held[d] = 1'b0;
    if (newp) begin
      m_tv = 1'b1; m_td = d;
    end else if (m_tv && rdy) begin
      m_tv = 1'b0;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic drive_cycle(input logic v, input logic [7:0] b, input logic rdy);
    rx_valid = v; rx_data = b; turn_ready = rdy;
    model_cycle(v, b, rdy);
    @(negedge CLOCK_50);
    rx_valid = 1'b0; turn_ready = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    drive_cycle(1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'h00, 1'b0);
  endtask

  // Reset asserted together with a press and a handshake, which it must override.
  task automatic do_reset();
    reset = 1'b1; rx_valid = 1'b1; rx_data = 8'h1D; turn_ready = 1'b1;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0; rx_valid = 1'b0; turn_ready = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (held !== 4'b0000) begin n_fail++; $display("FAIL reset_held: got %b expected 0000", held); end
    n_checks++; if (dir_out !== 4'b0000) begin n_fail++; $display("FAIL reset_dir_out: got %b expected 0000", dir_out); end
    n_checks++; if (turn_valid !== 1'b0) begin n_fail++; $display("FAIL reset_turn_valid: got %b expected 0", turn_valid); end
    n_checks++; if (turn_dir !== 2'd0) begin n_fail++; $display("FAIL reset_turn_dir: got %0d expected 0", turn_dir); end
  endtask

  task automatic test_single_press();
    do_reset();
    send(8'h1D);
    n_checks++; if (held !== 4'b1000) begin n_fail++; $display("FAIL single_held: got %b expected 1000", held); end
    n_checks++; if (dir_out !== 4'b1000) begin n_fail++; $display("FAIL single_dir_out: got %b expected 1000", dir_out); end
    n_checks++; if (turn_valid !== 1'b1) begin n_fail++; $display("FAIL single_turn_valid: got %b expected 1", turn_valid); end
    n_checks++; if (turn_dir !== 2'd0) begin n_fail++; $display("FAIL single_turn_dir: got %0d expected 0", turn_dir); end
    idle(1);
    n_checks++; if (turn_valid !== 1'b1) begin n_fail++; $display("FAIL single_wait_valid: got %b expected 1", turn_valid); end
    drive_cycle(1'b0, 8'h00, 1'b1);
    n_checks++; if (turn_valid !== 1'b0) begin n_fail++; $display("FAIL single_handshake: got %b expected 0", turn_valid); end
  endtask

  task automatic test_release_arbitration();
    do_reset();
    send(8'h1D);
    n_checks++; if (dir_out !== 4'b1000) begin n_fail++; $display("FAIL arb_up: got %b expected 1000", dir_out); end
    send(8'h23);
    n_checks++; if (dir_out !== 4'b0001) begin n_fail++; $display("FAIL arb_right: got %b expected 0001", dir_out); end
    n_checks++; if (held !== 4'b1001) begin n_fail++; $display("FAIL arb_held_both: got %b expected 1001", held); end
    n_checks++; if (turn_dir !== 2'd3) begin n_fail++; $display("FAIL arb_turn_dir: got %0d expected 3", turn_dir); end
    send(8'hF0);
    n_checks++; if (held !== 4'b1001) begin n_fail++; $display("FAIL arb_prefix_only: got %b expected 1001", held); end
    send(8'h23);
    n_checks++; if (dir_out !== 4'b1000) begin n_fail++; $display("FAIL arb_after_release: got %b expected 1000", dir_out); end
    n_checks++; if (held !== 4'b1000) begin n_fail++; $display("FAIL arb_held_end: got %b expected 1000", held); end
  endtask

  task automatic test_typematic();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(8'h1C);
      n_checks++; if (turn_valid !== 1'b1 || turn_dir !== 2'd2) begin n_fail++; $display("FAIL repeat_req[%0d]: got valid %b dir %0d expected valid 1 dir 2", i, turn_valid, turn_dir); end
    end
    n_checks++; if (dir_out !== 4'b0010) begin n_fail++; $display("FAIL repeat_dir_out: got %b expected 0010", dir_out); end
    drive_cycle(1'b0, 8'h00, 1'b1);
    n_checks++; if (turn_valid !== 1'b0) begin n_fail++; $display("FAIL repeat_handshake: got %b expected 0", turn_valid); end
    idle(1);
    n_checks++; if (turn_valid !== 1'b0) begin n_fail++; $display("FAIL repeat_single_req: got %b expected 0", turn_valid); end
    send(8'h1C);
    n_checks++; if (turn_valid !== 1'b0) begin n_fail++; $display("FAIL repeat_no_rereq: got %b expected 0", turn_valid); end
  endtask

  task automatic test_latest_wins();
    do_reset();
    send(8'h1B);
    send(8'h1C);
    n_checks++; if (turn_valid !== 1'b1 || turn_dir !== 2'd2) begin n_fail++; $display("FAIL latest_overwrite: got valid %b dir %0d expected valid 1 dir 2", turn_valid, turn_dir); end
    n_checks++; if (held !== 4'b0110 || dir_out !== 4'b0010) begin n_fail++; $display("FAIL latest_held_dir: got held %b dir %b expected 0110 0010", held, dir_out); end
    drive_cycle(1'b1, 8'h1D, 1'b1);
    n_checks++; if (turn_valid !== 1'b1 || turn_dir !== 2'd0) begin n_fail++; $display("FAIL latest_press_on_handshake: got valid %b dir %0d expected valid 1 dir 0", turn_valid, turn_dir); end
    idle(2);
    n_checks++; if (turn_valid !== 1'b1 || turn_dir !== 2'd0) begin n_fail++; $display("FAIL latest_stable: got valid %b dir %0d expected valid 1 dir 0", turn_valid, turn_dir); end
    drive_cycle(1'b0, 8'h00, 1'b1);
    n_checks++; if (turn_valid !== 1'b0) begin n_fail++; $display("FAIL latest_clear: got %b expected 0", turn_valid); end
  endtask

  task automatic test_extended();
    logic [3:0] exp_up;
    exp_up = EXT_EN ? 4'b1000 : 4'b0000;
    do_reset();
    send(8'hE0);
    send(8'h75);
    n_checks++; if (dir_out !== exp_up) begin n_fail++; $display("FAIL ext_press: got %b expected %b", dir_out, exp_up); end
    n_checks++; if (held !== exp_up) begin n_fail++; $display("FAIL ext_press_held: got %b expected %b", held, exp_up); end
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    n_checks++; if (dir_out !== 4'b0000) begin n_fail++; $display("FAIL ext_release: got %b expected 0000", dir_out); end
    send(8'hE0);
    send(8'h1D);
    n_checks++; if (held !== 4'b0000) begin n_fail++; $display("FAIL ext_plain_code_consumed: got %b expected 0000", held); end
    send(8'h1D);
    n_checks++; if (held !== 4'b1000) begin n_fail++; $display("FAIL ext_back_to_idle: got %b expected 1000", held); end
  endtask

  task automatic test_timeout_and_reset();
    do_reset();
    send(8'hF0);
    idle(TB_T);
    send(8'h1D);
    n_checks++; if (held !== 4'b1000 || turn_valid !== 1'b1 || turn_dir !== 2'd0) begin n_fail++; $display("FAIL timeout_press: got held %b valid %b dir %0d expected 1000 1 0", held, turn_valid, turn_dir); end
    send(8'hF0);
    idle(TB_T - 3);
    send(8'h1D);
    n_checks++; if (held !== 4'b0000) begin n_fail++; $display("FAIL before_timeout_release: got %b expected 0000", held); end
    send(8'h1C);
    send(8'hE0);
    do_reset();
    n_checks++; if (held !== 4'b0000 || dir_out !== 4'b0000 || turn_valid !== 1'b0 || turn_dir !== 2'd0) begin n_fail++; $display("FAIL midseq_reset: got held %b dir %b valid %b tdir %0d expected all 0", held, dir_out, turn_valid, turn_dir); end
    send(8'hF0);
    do_reset();
    send(8'h1D);
    n_checks++; if (held !== 4'b1000) begin n_fail++; $display("FAIL reset_drops_prefix: got %b expected 1000", held); end
  endtask

  task automatic test_random();
    logic [7:0] codes [13];
    logic rdy;
    int r;
    codes = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74,
              8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h12};
    do_reset();
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 99);
      rdy = ($urandom_range(0, 2) == 0);
      if (r < 4) idle(($urandom_range(0, 1) == 0) ? TB_T - 3 : TB_T + 1);
      if (r < 65) drive_cycle(1'b1, codes[$urandom_range(0, 12)], rdy);
      else drive_cycle(1'b0, 8'h00, rdy);
      n_checks++; if (held !== m_held_vec()) begin n_fail++; $display("FAIL rand_held[%0d]: got %b expected %b", c, held, m_held_vec()); end
      n_checks++; if (dir_out !== m_dir_vec()) begin n_fail++; $display("FAIL rand_dir_out[%0d]: got %b expected %b", c, dir_out, m_dir_vec()); end
      n_checks++; if (turn_valid !== m_tv) begin n_fail++; $display("FAIL rand_turn_valid[%0d]: got %b expected %b", c, turn_valid, m_tv); end
      n_checks++; if (m_tv && (turn_dir !== 2'(m_td))) begin n_fail++; $display("FAIL rand_turn_dir[%0d]: got %0d expected %0d", c, turn_dir, m_td); end
    end
  endtask

  initial begin
    model_reset();
    @(negedge CLOCK_50);
    test_reset();
    test_single_press();
    test_release_arbitration();
    test_typematic();
    test_latest_wins();
    test_extended();
    test_timeout_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end of test, expected completion");
    $fatal(1);
  end

endmodule
